// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: transfer size codes, FSM states
// and the alignment rule used when accepting a request.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    function automatic logic is_aligned(input size_e sz, input logic [1:0] lo);
        logic ok;
        case (sz)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~lo[0];
            SZ_WORD: ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane handling: store byte enables and data replication from the live
// request, load lane extraction and sign/zero extension from the captured request.
module load_store_align
    import mem_pkg::*;
(
    input  size_e       st_size_i,
    input  logic [1:0]  st_lo_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  size_e       ld_size_i,
    input  logic [1:0]  ld_lo_i,
    input  logic        ld_signed_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] shifted;

    always_comb begin
        st_be_o    = '0;
        st_wdata_o = st_data_i;
        case (st_size_i)
            SZ_BYTE: begin
                st_be_o    = 4'b0001 << st_lo_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            SZ_HALF: begin
                st_be_o    = st_lo_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            SZ_WORD: st_be_o = 4'b1111;
            default: st_be_o = '0;
        endcase
    end

    // Requests are aligned, so shifting by the byte offset lands the lane at bit 0.
    assign shifted = ld_rdata_i >> {ld_lo_i, 3'b000};

    always_comb begin
        ld_data_o = '0;
        case (ld_size_i)
            SZ_BYTE: ld_data_o = {{24{ld_signed_i & shifted[7]}}, shifted[7:0]};
            SZ_HALF: ld_data_o = {{16{ld_signed_i & shifted[15]}}, shifted[15:0]};
            SZ_WORD: ld_data_o = shifted;
            default: ld_data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: runs one req/ack data-bus transaction per accepted
// execute result, with alignment checks, load extension and a bus timeout.
module mem_access
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_memRead,
    input  logic        i_memWrite,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic        i_nop,
    input  logic [31:0] i_ALUres,
    input  logic [31:0] i_op2,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result,
    output logic        o_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  lo_q, lo_d;
    size_e       size_q, size_d;
    logic        sgn_q, sgn_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] result_q, result_d;

    size_e       in_size;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic        mem_op;
    logic        illegal;
    logic        timed_out;

    assign in_size = size_e'(i_size);

    load_store_align u_align (
        .st_size_i   (in_size),
        .st_lo_i     (i_ALUres[1:0]),
        .st_data_i   (i_op2),
        .st_be_o     (st_be),
        .st_wdata_o  (st_wdata),
        .ld_size_i   (size_q),
        .ld_lo_i     (lo_q),
        .ld_signed_i (sgn_q),
        .ld_rdata_i  (i_mem_rdata),
        .ld_data_o   (ld_data)
    );

    assign mem_op    = (i_memRead | i_memWrite) & ~i_nop;
    assign illegal   = (i_memRead & i_memWrite) | ~is_aligned(in_size, i_ALUres[1:0]);
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            lo_q     <= '0;
            size_q   <= SZ_BYTE;
            sgn_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
            size_q   <= size_d;
            sgn_q    <= sgn_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        lo_d     = lo_q;
        size_d   = size_q;
        sgn_d    = sgn_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    if (!mem_op) begin
                        done_d   = 1'b1;
                        result_d = i_ALUres;
                    end else if (illegal) begin
                        done_d   = 1'b1;
                        err_d    = 1'b1;
                        result_d = '0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = i_memWrite;
                        addr_d  = {i_ALUres[31:2], 2'b00};
                        be_d    = st_be;
                        wdata_d = st_wdata;
                        lo_d    = i_ALUres[1:0];
                        size_d  = in_size;
                        sgn_d   = i_signed;
                    end
                end
            end
            ST_WAIT: begin
                // Ack is checked first so an ack on the final allowed cycle still completes.
                if (i_mem_ack) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    done_d   = 1'b1;
                    result_d = we_q ? 32'h0 : ld_data;
                end else if (timed_out) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    result_d = '0;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_busy      = (state_q == ST_WAIT);
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_result    = result_q;
    assign o_mem_req   = req_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_be    = be_q;
    assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed and randomized checks of mem_access against an arithmetic model of
// the byte-lane, extension, alignment and timeout rules.
module tb_mem_access;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sgn_in = 1'b0;
    logic        nop = 1'b0;
    logic [31:0] alu_res = '0;
    logic [31:0] op2_in = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] result, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;

    mem_access #(.TIMEOUT(TO)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .i_memRead   (mem_read),
        .i_memWrite  (mem_write),
        .i_size      (size),
        .i_signed    (sgn_in),
        .i_nop       (nop),
        .i_ALUres    (alu_res),
        .i_op2       (op2_in),
        .o_busy      (busy),
        .o_done      (done),
        .o_result    (result),
        .o_err       (err),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_be    (mem_be),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ref_be(input int nb, input int lo);
        logic [63:0] m;
        m = ((64'd1 << nb) - 64'd1) << lo;
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] d, input int nb);
        logic [31:0] w;
        logic [31:0] sh;
        for (int i = 0; i < 4; i++) begin
            sh = d >> (8 * (i % nb));
            w[8*i +: 8] = sh[7:0];
        end
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input int lo, input int nb,
                                             input logic sg);
        logic [63:0] v, mask;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v = ({32'b0, rd} >> (8 * lo)) & mask;
        if (sg && nb < 4 && v[8*nb-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic run_alu(input logic [31:0] val, input logic a_nop, input logic rd,
                           input logic wr);
        valid = 1'b1; nop = a_nop; mem_read = rd; mem_write = wr; alu_res = val;
        size = 2'(($urandom_range(0, 3)));
        chk("alu_busy_pre", 32'(busy), 32'd0);
        step();
        valid = 1'b0; nop = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        chk("alu_done", 32'(done), 32'd1);
        chk("alu_err", 32'(err), 32'd0);
        chk("alu_result", result, val);
        chk("alu_busy", 32'(busy), 32'd0);
        chk("alu_req", 32'(mem_req), 32'd0);
    endtask

    task automatic run_mem(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic a_sgn, input logic [31:0] addr, input logic [31:0] a_op2,
                           input logic [31:0] a_rdata, input int ack_at);
        int nb, lo, reqcyc, exp_cyc;
        logic legal, tmo;
        nb = 1 << sz;
        lo = int'(addr[1:0]);
        legal = (rd ^ wr) && (sz != 2'b11) && (lo % nb == 0);
        valid = 1'b1; nop = 1'b0; mem_read = rd; mem_write = wr; size = sz;
        sgn_in = a_sgn; alu_res = addr; op2_in = a_op2; mem_rdata = a_rdata;
        step();
        valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        if (!legal) begin
            chk("ill_done", 32'(done), 32'd1);
            chk("ill_err", 32'(err), 32'd1);
            chk("ill_result", result, 32'd0);
            chk("ill_req", 32'(mem_req), 32'd0);
            chk("ill_busy", 32'(busy), 32'd0);
            return;
        end
        chk("req_busy", 32'(busy), 32'd1);
        chk("req_done_low", 32'(done), 32'd0);
        chk("req_we", 32'(mem_we), 32'(wr));
        if (wr) chk("req_wdata", mem_wdata, ref_wdata(a_op2, nb));
        reqcyc = 0;
        while (mem_req && reqcyc < 40) begin
            chk("req_addr", mem_addr, {addr[31:2], 2'b00});
            chk("req_be", 32'(mem_be), 32'(ref_be(nb, lo)));
            reqcyc++;
            if (reqcyc == ack_at) mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
        end
        tmo = !(ack_at >= 1 && ack_at <= int'(TO));
        exp_cyc = tmo ? int'(TO) : ack_at;
        chk("req_cycles", 32'(reqcyc), 32'(exp_cyc));
        chk("cpl_done", 32'(done), 32'd1);
        chk("cpl_err", 32'(err), 32'(tmo));
        chk("cpl_result", result, (tmo || wr) ? 32'd0 : ref_load(a_rdata, lo, nb, a_sgn));
        chk("cpl_busy", 32'(busy), 32'd0);
    endtask

    task automatic idle_check();
        step();
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_req", 32'(mem_req), 32'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        idle_check();

        run_mem(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 3);
        idle_check();
        run_mem(1'b1, 1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80112233, 1);
        run_mem(1'b1, 1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h80112233, 2);
        run_mem(1'b1, 1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 32'h9ABC0000, 1);
        run_mem(1'b1, 1'b0, 2'b01, 1'b1, 32'h201, 32'h0, 32'h9ABC0000, 1);
        idle_check();

        run_alu(32'h12345678, 1'b0, 1'b0, 1'b0);
        run_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 2);
        run_alu(32'h0BADF00D, 1'b1, 1'b1, 1'b0);
        idle_check();

        run_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 32'h11111111, 0);
        run_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h84, 32'h0, 32'h22222222, 16);
        idle_check();

        mem_ack = 1'b1;
        repeat (3) idle_check();
        mem_ack = 1'b0;

        run_mem(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1);
        run_mem(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1);
        run_mem(1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1);
        idle_check();

        valid = 1'b1; mem_write = 1'b1; size = 2'b10; alu_res = 32'h100; op2_in = 32'h55AA55AA;
        step();
        valid = 1'b0; mem_write = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("postrst_done", 32'(done), 32'd0);
        idle_check();
        run_mem(1'b0, 1'b1, 2'b00, 1'b0, 32'h001, 32'h000000A5, 32'h0, 2);
        chk("sb_be_model", 32'(ref_be(1, 1)), 32'h2);

        for (int n = 0; n < 40; n++) begin
            int kind, rw, ack_at;
            logic [31:0] a;
            kind = int'($urandom_range(0, 9));
            a = $urandom;
            if (kind == 0) begin
                run_alu(a, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end else begin
                rw = int'($urandom_range(0, 5));
                ack_at = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
                run_mem(rw == 0 || rw <= 2, rw == 0 || rw >= 3, 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), a, $urandom, $urandom, ack_at);
            end
            if ($urandom_range(0, 2) == 0) idle_check();
        end
        idle_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
Memory-access stage directly downstream of the execute stage. It consumes the ALU result (the effective address, or a pass-through value) and the forwarded rt operand (store data). It runs a request/acknowledge transaction on the data-memory bus, handles byte lanes, alignment, load sign/zero extension and bus timeout. It produces the write-back value and holds the core in stall while busy.

Parameters:
TIMEOUT, 16, WAIT cycles without ack before abort with error; 0 = never time out

Ports:
i_clk  in  1  core clock, rising edge
i_rst  in  1  asynchronous active-high reset
i_valid  in  1  execute result valid; sampled only in IDLE
i_memRead  in  1  load
i_memWrite  in  1  store
i_size  in  2  00 byte, 01 half, 10 word, 11 reserved
i_signed  in  1  sign-extend loads (LB/LH) when 1, zero-extend (LBU/LHU) when 0
i_nop  in  1  NOP from execute; forces a non-memory op
i_ALUres  in  32  address or pass-through value
i_op2  in  32  store data
o_busy  out  1  state != IDLE (combinational from state); stalls PC/execute
o_done  out  1  one-cycle pulse: o_result/o_err valid
o_result  out  32  load data (aligned, extended) or registered i_ALUres
o_err  out  1  misaligned, reserved size, read&write, or timeout
o_mem_req  out  1  bus request, registered
o_mem_we  out  1  write strobe
o_mem_addr  out  32  {addr[31:2],2'b00}
o_mem_be  out  4  byte enables
o_mem_wdata  out  32  lane-replicated store data
i_mem_rdata  in  32  read data, valid with ack
i_mem_ack  in  1  completes request; ignored unless o_mem_req=1

Behaviour:
- States: IDLE, WAIT. Reset: IDLE; every output 0; timeout counter 0.
- IDLE, i_valid=1, memory op (read XOR write, no i_nop), legal size, aligned: capture address, size, signed and store data. Next cycle enter WAIT with o_mem_req=1.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=00; byte always aligned.
- Illegal op (misaligned, size 11, or read&write both set): no bus request. Next cycle: o_done=1, o_err=1, o_result=0. State stays IDLE.
- Non-memory op (neither read nor write, or i_nop=1): next cycle o_done=1, o_result=i_ALUres, o_err=0.
- WAIT: o_mem_req, o_mem_we, o_mem_addr, o_mem_be and o_mem_wdata stay stable until ack. On i_mem_ack at an edge: drop req, return to IDLE. o_done=1 in the following cycle, with o_result = extracted load data (0 for stores).
- Timeout: counter increments each WAIT cycle without ack. When it equals TIMEOUT: drop req, IDLE, o_done=1, o_err=1, o_result=0. An ack arriving in the same cycle as the timeout wins.
- Byte lanes are little-endian: byte n occupies bits [8n+7:8n].
  - be: byte 0001<<addr[1:0]; half addr[1]?1100:0011; word 1111.
  - wdata: byte {4{op2[7:0]}}; half {2{op2[15:0]}}; word op2.
- Load extract: select the lane by addr[1:0], then sign- or zero-extend to 32 bits per the captured i_signed.
- o_done is high for exactly one cycle. A new i_valid is accepted in the same cycle o_done is high (back-to-back, one-cycle turnaround).
- i_valid is ignored while busy; upstream holds it under o_busy.
- Reset mid-WAIT: req drops immediately (async), no o_done, counter cleared.
- Ack while no req pending: ignored, no state change.

Decomposition:
- Shared package mem_pkg holds:
  - size codes SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - state encodings ST_IDLE, ST_WAIT.
- Sub-module load_store_align: combinational byte-enable, store replication and load extract/extend. Keeps the FSM file to control logic only.

Test Plan:
- SW, addr 0x100, op2 0xDEADBEEF, ack on 3rd WAIT cycle -> req for exactly 3 cycles with addr 0x100, be 1111, wdata 0xDEADBEEF; o_done next cycle; o_err 0.
- LB signed, addr 0x203, rdata 0x80112233 -> be 1000, o_result 0xFFFFFF80. Repeat unsigned -> 0x00000080.
- LH signed, addr 0x202, rdata 0x9ABC0000 -> o_result 0xFFFF9ABC. LH at addr 0x201 -> no req; o_done, o_err 1, o_result 0.
- Non-memory op, ALUres 0x12345678 -> o_done one cycle later with o_result 0x12345678, o_busy never asserted. Then an immediate back-to-back LW is accepted on the o_done cycle.
- TIMEOUT=16, no ack -> req high 16 cycles, then drops; o_done, o_err 1. With ack in cycle 16 -> normal completion, o_err 0.
- Assert i_rst in WAIT cycle 2 -> o_mem_req drops asynchronously, no o_done. After release, a new SB at 0x001 -> be 0010, wdata replicated byte.
